mc_controller: RTL and testbench

- Multicycle MIPS control unit: the producer side of the ALU control interface. It generates the 4-bit ALU function code `f` plus all datapath enables, and consumes the ALU `zero` flag.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback states.
- It sits between the instruction register (op/funct) and the datapath muxes and enables.

---
 rtl/mips_pkg.sv | 79 +++++++
 rtl/alu_dec.sv | 26 ++
 rtl/mc_controller.sv | 165 ++++++++++++++++
 tb/tb_mc_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// ALU function codes, FSM state encoding and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_BLEZ = 4'b1010;
    localparam logic [3:0] ALU_SRLV = 4'b1011;
    localparam logic [3:0] ALU_SRL  = 4'b1100;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    function automatic logic op_known(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_BLEZ,
            OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW: op_known = 1'b1;
            default:                               op_known = 1'b0;
        endcase
    endfunction

    function automatic logic funct_known(input logic [5:0] funct);
        case (funct)
            FN_SLL, FN_SRL, FN_SRLV, FN_ADD, FN_SUB,
            FN_AND, FN_OR, FN_XOR, FN_SLT: funct_known = 1'b1;
            default:                       funct_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// R-type funct to ALU function code decoder; purely combinational.
// Unrecognised funct yields code 0000.
module alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_f
);

    always_comb begin
        o_f = ALU_AND;
        case (i_funct)
            FN_ADD:  o_f = ALU_ADD;
            FN_SUB:  o_f = ALU_SUB;
            FN_AND:  o_f = ALU_AND;
            FN_OR:   o_f = ALU_OR;
            FN_XOR:  o_f = ALU_XOR;
            FN_SLT:  o_f = ALU_SLT;
            FN_SLL:  o_f = ALU_SLL;
            FN_SRL:  o_f = ALU_SRL;
            FN_SRLV: o_f = ALU_SRLV;
            default: o_f = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: Moore outputs from state, pcen also depends on zero.
// MC_ILLEGAL_TRAP_EN adds a sticky HALT state for unknown op/funct (left only by reset).
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] f,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [3:0] state,
    output logic       illegal
);

    state_t     r_state;
    logic [3:0] w_f_rtype;
    logic       w_pcen;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;

    alu_dec u_alu_dec (
        .i_funct (funct),
        .o_f     (w_f_rtype)
    );

`ifdef MC_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_trap;

    assign w_trap = !op_known(op) || ((op == OP_RTYPE) && !funct_known(funct));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW:             r_state <= S_MEMADR;
                        OP_RTYPE:                 r_state <= S_RTYPEEX;
                        OP_BEQ, OP_BNE, OP_BLEZ:  r_state <= S_BRANCH;
                        OP_ADDI, OP_ORI, OP_LUI:  r_state <= S_IMMEX;
                        OP_J:                     r_state <= S_JUMP;
                        default:                  r_state <= S_FETCH;
                    endcase
`ifdef MC_ILLEGAL_TRAP_EN
                    if (w_trap) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end
`endif
                end
                S_MEMADR:  r_state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   r_state <= S_MEMWB;
                S_RTYPEEX: r_state <= S_ALUWB;
                S_IMMEX:   r_state <= S_IMMWB;
`ifdef MC_ILLEGAL_TRAP_EN
                S_HALT:    r_state <= S_HALT;
`endif
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        f          = ALU_ADD;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REGB;
        zeroext    = 1'b0;
        pcsrc      = PC_ALU;
        w_pcen     = 1'b0;
        iord       = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        w_regwrite = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb   = SRCB_FOUR;
                w_irwrite = 1'b1;
                w_pcen    = 1'b1;
            end
            S_DECODE:  alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                f       = w_f_rtype;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                pcsrc   = PC_ALUOUT;
                case (op)
                    OP_BEQ:  begin f = ALU_SUB;  w_pcen = zero;  end
                    OP_BNE:  begin f = ALU_SUB;  w_pcen = !zero; end
                    OP_BLEZ: begin f = ALU_BLEZ; w_pcen = zero;  end
                    default: w_pcen = 1'b0;
                endcase
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                case (op)
                    OP_ORI:  begin f = ALU_OR; zeroext = 1'b1; end
                    OP_LUI:  f = ALU_LUI;
                    default: f = ALU_ADD;
                endcase
            end
            S_IMMWB:   w_regwrite = 1'b1;
            S_JUMP: begin
                pcsrc  = PC_JUMP;
                w_pcen = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are gated by reset itself so nothing commits while reset is high.
    assign pcen     = w_pcen     & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign irwrite  = w_irwrite  & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign state    = r_state;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed-vector bench for mc_controller with hand-computed expectations.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] f;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [3:0] state;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    mc_controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .f        (f),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .zeroext  (zeroext),
        .pcsrc    (pcsrc),
        .pcen     (pcen),
        .iord     (iord),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .state    (state),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b100000;
        zero  = 1'b0;
        #3;
        chk("rst_state", state, 4'd0);
        chk("rst_irwrite", irwrite, 1'b0);
        chk("rst_pcen", pcen, 1'b0);
        chk("rst_alusrcb", alusrcb, 2'b01);
        chk("rst_illegal", illegal, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("fetch_irwrite", irwrite, 1'b1);
        chk("fetch_pcen", pcen, 1'b1);
        chk("fetch_f", f, 4'b0010);

        // lw: 0,1,2,3,4,0
        op = 6'b100011;
        step(); chk("lw_s1", state, 4'd1);
        chk("dec_alusrcb", alusrcb, 2'b11);
        chk("dec_irwrite", irwrite, 1'b0);
        step(); chk("lw_s2", state, 4'd2);
        chk("memadr_srcb", alusrcb, 2'b10);
        chk("memadr_srca", alusrca, 1'b1);
        step(); chk("lw_s3", state, 4'd3);
        chk("memrd_iord", iord, 1'b1);
        step(); chk("lw_s4", state, 4'd4);
        chk("memwb_memtoreg", memtoreg, 1'b1);
        chk("memwb_regwrite", regwrite, 1'b1);
        chk("memwb_regdst", regdst, 1'b0);
        step(); chk("lw_s0", state, 4'd0);

        // sw, then asynchronous reset in MEMWR
        op = 6'b101011;
        step(); step(); step();
        chk("sw_s5", state, 4'd5);
        chk("memwr_memwrite", memwrite, 1'b1);
        chk("memwr_iord", iord, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("arst_memwrite", memwrite, 1'b0);
        chk("arst_state", state, 4'd0);
        reset = 1'b0;
        #1;
        chk("rel_irwrite", irwrite, 1'b1);
        chk("rel_pcen", pcen, 1'b1);

        // R-type sub and srlv
        op = 6'b000000; funct = 6'b100010;
        step(); step();
        chk("rsub_s6", state, 4'd6);
        chk("rsub_f", f, 4'b0110);
        chk("rsub_srcb", alusrcb, 2'b00);
        step(); chk("rsub_s7", state, 4'd7);
        chk("aluwb_regdst", regdst, 1'b1);
        chk("aluwb_regwrite", regwrite, 1'b1);
        step(); chk("rsub_s0", state, 4'd0);
        funct = 6'b000110;
        step(); step();
        chk("rsrlv_f", f, 4'b1011);
        step(); step(); chk("rsrlv_s0", state, 4'd0);

        // beq taken / not taken
        op = 6'b000100; zero = 1'b1;
        step(); step();
        chk("beq_s8", state, 4'd8);
        chk("beq_pcen_t", pcen, 1'b1);
        chk("beq_pcsrc", pcsrc, 2'b01);
        chk("beq_f", f, 4'b0110);
        zero = 1'b0;
        #1;
        chk("beq_pcen_nt", pcen, 1'b0);
        step(); chk("beq_s0", state, 4'd0);

        // bne with zero=0, blez
        op = 6'b000101;
        step(); step();
        chk("bne_pcen", pcen, 1'b1);
        step();
        op = 6'b000110; zero = 1'b1;
        step(); step();
        chk("blez_f", f, 4'b1010);
        chk("blez_pcen", pcen, 1'b1);
        step();

        // ori, lui
        op = 6'b001101; zero = 1'b0;
        step(); step();
        chk("ori_s9", state, 4'd9);
        chk("ori_f", f, 4'b0001);
        chk("ori_zeroext", zeroext, 1'b1);
        step(); chk("ori_s10", state, 4'd10);
        chk("immwb_regwrite", regwrite, 1'b1);
        chk("immwb_regdst", regdst, 1'b0);
        step();
        op = 6'b001111;
        step(); step();
        chk("lui_f", f, 4'b1000);
        chk("lui_zeroext", zeroext, 1'b0);
        step(); step(); chk("lui_s0", state, 4'd0);

        // jump
        op = 6'b000010;
        step(); step();
        chk("j_s11", state, 4'd11);
        chk("j_pcsrc", pcsrc, 2'b10);
        chk("j_pcen", pcen, 1'b1);
        step(); chk("j_s0", state, 4'd0);

        // unknown opcode
        op = 6'b111111;
        step();
        chk("ill_s1", state, 4'd1);
        chk("ill_dec_regwrite", regwrite, 1'b0);
        chk("ill_dec_memwrite", memwrite, 1'b0);
        step();
`ifdef MC_ILLEGAL_TRAP_EN
        chk("ill_halt", state, 4'd12);
        chk("ill_flag", illegal, 1'b1);
        op = 6'b100011;
        step(); step();
        chk("ill_hold", state, 4'd12);
        chk("ill_sticky", illegal, 1'b1);
        chk("ill_pcen", pcen, 1'b0);
        chk("ill_irwrite", irwrite, 1'b0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("ill_rst_state", state, 4'd0);
        chk("ill_rst_flag", illegal, 1'b0);
`else
        chk("ill_nop_s0", state, 4'd0);
        chk("ill_flag_tied", illegal, 1'b0);
        chk("ill_nop_regwrite", regwrite, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
